instruction_sequencer: RTL and testbench
========================================

Name: instruction_sequencer

Overview:
- Microsequencer for the relay-computer datapath.
- Fetches each opcode through the 16-bit address bus, then steps the register-file and program-control load/select strobes and the ALU function code one state per clock.
- Sits between the program memory/condition-flag logic and the existing control-signal bundle; it is the only driver of every Ld*/Sel* strobe.

Parameters:
- NREGS, 8, register-file index space (A,B,C,D,M1,M2,X,Y = 0..7)
- HALT_OPCODE, 8'hAE, opcode that parks the sequencer

Ports:
- clock  input  1  system clock, all state on rising edge
- reset_n  input  1  asynchronous active-low reset
- run  input  1  level; leaving HALT requires run=1
- inst  input  8  current Inst register contents
- flagZ, flagC, flagS  input  1 each  condition flags (zero, carry, sign)
- ld  output  8  register-file load strobes, one-hot, index = register number
- sel  output  8  register-file bus-select strobes, one-hot
- ldJ1, ldJ2, ldInst, ldPC, ldINC, ldXY  output  1 each  program-control loads
- selM, selXY, selJ, selPC, selINC  output  1 each  address-bus source selects
- aluFunctionCode  output  3  ALU function
- immEn  output  1  sequencer drives immData onto the data bus
- immData  output  8  sign-extended SETAB value
- memRead, memWrite  output  1 each  memory strobes
- halted  output  1  high in HALT
- illegal  output  1  one-cycle pulse on an undefined opcode

Behaviour:
- State register uses an asynchronous clear. Reset state is HALT.
- In HALT every strobe output is 0, immData=0, halted=1 and illegal=0.
- All outputs are a Moore decode of state plus inst. No output changes mid-cycle except through inst.
- Fetch, every instruction:
  - F0: selPC, ldINC, memRead, ldInst
  - F1: selINC, ldPC
  - F1 goes to EX0.
- Execute, decoded from inst in EX0:
  - 00dddsss MOV8: sel[s], ld[d]. d==s is legal and loads the register onto itself.
  - 01rvvvvv SETAB: immEn, immData = sign-extend(vvvvv); ld[A] if r=0, ld[B] if r=1.
  - 1000rfff ALU: aluFunctionCode=fff; ld[A] if r=0, ld[D] if r=1.
  - 100100rr LOAD: selM, memRead, ld[rr].
  - 100110rr STORE: selM, sel[rr], memWrite.
  - HALT_OPCODE: next state HALT, no strobes.
  - 11dcccc GOTO (d=bit5, cccc=bits3:0, bit4 ignored):
    - J0: selPC, ldINC, memRead, ldJ1
    - J1: selINC, ldPC
    - J2: selPC, ldINC, memRead, ldJ2
    - J3: selINC, ldPC
    - If d=1, J4: selINC, ldXY. This links the return address to XY.
    - J5, only when taken: selJ, ldPC.
    - Taken when cccc==0, or (c3&flagS)|(c2&flagC)|(c1&flagZ)|(c0&~flagZ).
  - Any other opcode: no strobes, illegal=1 for that EX0 cycle, treated as a no-op.
- After the last execute state:
  - run=1: go to F0.
  - run=0: go to HALT.
- From HALT, go to F0 on the first rising edge with run=1.
- Latency in clocks:
  - 3 for single-cycle classes
  - GOTO: 6 not taken; 7 taken without link or not taken with link; 8 taken with link
- Flags are sampled in the state preceding J5. Flag changes during J0–J3 are honoured.
- ld and sel are each one-hot or zero. Two ld bits or two sel bits are never high in the same cycle.
- Reset asserted mid-instruction: all strobes drop to 0 immediately (asynchronous). The sequencer restarts from HALT, and the partial instruction is not resumed.
- run deasserted mid-instruction: the instruction completes, then HALT.

Decomposition:
- Package seq_pkg holds:
  - state_t enum: HALT, F0, F1, EX0, J0–J5
  - register index constants REG_A..REG_Y
  - opcode-class mask/match constants
  - HALT_OPCODE default
- One sub-module, seq_decode: purely combinational. Maps (state, inst, flags) to the strobe vector and next state; the top holds only the state flop.

Test Plan:
- Reset low, run=1 → all strobes 0, halted=1. Release reset → F0 on next edge: selPC=1, ldINC=1, memRead=1, ldInst=1.
- inst=8'b00_000_011 (MOV A←D) → EX0 has sel=8'b00001000, ld=8'b00000001; 3 clocks total.
- inst=8'b01_0_11110 (SETAB A,-2) → immData=8'hFE, immEn=1, ld[0]=1. inst=8'b1000_1_101 → aluFunctionCode=3'b101, ld[3]=1.
- inst=8'b11_1_0_0010 (jump-link if zero), flagZ=1 → J0–J5 visited, ldXY in J4, selJ+ldPC in J5, 8 clocks. Repeat with flagZ=0 → J5 skipped, 7 clocks.
- inst=8'hAE → halted=1 after EX0 and outputs stay 0 while run=0. Raise run → F0 follows.
- inst=8'b1011_0001 → illegal pulses exactly one cycle, no ld/sel. Then assert reset_n=0 during J2 of a GOTO → strobes clear asynchronously and state is HALT.

Source files
------------

// File: rtl/seq_pkg.sv
// seq_pkg -- shared definitions for the relay-computer microsequencer.
//   state_t     : sequencer states (HALT, fetch F0/F1, execute EX0, GOTO J0..J5)
//   REG_*       : register-file indices used by ld/sel strobes
//   *_MASK/MATCH: opcode class recognisers
//   ctl_t       : program-control, address-select and memory strobes
package seq_pkg;

    localparam int         NREGS_DEF       = 8;
    localparam logic [7:0] HALT_OPCODE_DEF = 8'hAE;

    localparam logic [2:0] REG_A  = 3'd0;
    localparam logic [2:0] REG_B  = 3'd1;
    localparam logic [2:0] REG_C  = 3'd2;
    localparam logic [2:0] REG_D  = 3'd3;
    localparam logic [2:0] REG_M1 = 3'd4;
    localparam logic [2:0] REG_M2 = 3'd5;
    localparam logic [2:0] REG_X  = 3'd6;
    localparam logic [2:0] REG_Y  = 3'd7;

    localparam logic [7:0] MOV_MASK    = 8'hC0;
    localparam logic [7:0] MOV_MATCH   = 8'h00;
    localparam logic [7:0] SETAB_MASK  = 8'hC0;
    localparam logic [7:0] SETAB_MATCH = 8'h40;
    localparam logic [7:0] ALU_MASK    = 8'hF0;
    localparam logic [7:0] ALU_MATCH   = 8'h80;
    localparam logic [7:0] LOAD_MASK   = 8'hFC;
    localparam logic [7:0] LOAD_MATCH  = 8'h90;
    localparam logic [7:0] STORE_MASK  = 8'hFC;
    localparam logic [7:0] STORE_MATCH = 8'h98;
    localparam logic [7:0] GOTO_MASK   = 8'hC0;
    localparam logic [7:0] GOTO_MATCH  = 8'hC0;

    typedef enum logic [3:0] {
        HALT, F0, F1, EX0, J0, J1, J2, J3, J4, J5
    } state_t;

    typedef struct packed {
        logic ld_j1;
        logic ld_j2;
        logic ld_inst;
        logic ld_pc;
        logic ld_inc;
        logic ld_xy;
        logic sel_m;
        logic sel_xy;
        logic sel_j;
        logic sel_pc;
        logic sel_inc;
        logic imm_en;
        logic mem_read;
        logic mem_write;
    } ctl_t;

    function automatic logic op_is(input logic [7:0] op, input logic [7:0] mask,
                                   input logic [7:0] match);
        return (op & mask) == match;
    endfunction

    // An empty condition field means "always"; otherwise any selected flag term fires.
    function automatic logic goto_taken(input logic [3:0] cond, input logic z,
                                        input logic c, input logic s);
        return (cond == 4'b0000) | (cond[3] & s) | (cond[2] & c)
             | (cond[1] & z) | (cond[0] & ~z);
    endfunction

endpackage

// File: rtl/seq_decode.sv
// seq_decode -- purely combinational state/opcode decoder for the sequencer.
//   i_state       : current sequencer state
//   i_inst        : Inst register contents
//   i_run         : run level, consulted only when an instruction finishes
//   i_flag_z/c/s  : condition flags, consulted in the state before J5
//   o_next_state  : state for the next clock
//   o_ld / o_sel  : one-hot register-file load / bus-select strobes
//   o_ctl         : program-control, address-select and memory strobes
//   o_alu_fn      : ALU function code
//   o_imm_data    : sign-extended SETAB immediate
//   o_halted      : high in HALT
//   o_illegal     : high in EX0 for an undefined opcode
module seq_decode
    import seq_pkg::*;
#(
    parameter int         NREGS       = NREGS_DEF,
    parameter logic [7:0] HALT_OPCODE = HALT_OPCODE_DEF
) (
    input  state_t           i_state,
    input  logic [7:0]       i_inst,
    input  logic             i_run,
    input  logic             i_flag_z,
    input  logic             i_flag_c,
    input  logic             i_flag_s,
    output state_t           o_next_state,
    output logic [NREGS-1:0] o_ld,
    output logic [NREGS-1:0] o_sel,
    output ctl_t             o_ctl,
    output logic [2:0]       o_alu_fn,
    output logic [7:0]       o_imm_data,
    output logic             o_halted,
    output logic             o_illegal
);

    localparam logic [NREGS-1:0] ONE = NREGS'(1);

    logic   w_link;
    logic   w_taken;
    state_t w_done_state;

    assign w_link       = i_inst[5];
    assign w_taken      = goto_taken(i_inst[3:0], i_flag_z, i_flag_c, i_flag_s);
    assign w_done_state = i_run ? F0 : HALT;

    always_comb begin
        o_next_state = HALT;
        o_ld         = '0;
        o_sel        = '0;
        o_ctl        = '0;
        o_alu_fn     = 3'b000;
        o_imm_data   = 8'h00;
        o_halted     = 1'b0;
        o_illegal    = 1'b0;

        case (i_state)
            HALT: begin
                o_halted     = 1'b1;
                o_next_state = i_run ? F0 : HALT;
            end
            F0: begin
                o_ctl.sel_pc   = 1'b1;
                o_ctl.ld_inc   = 1'b1;
                o_ctl.mem_read = 1'b1;
                o_ctl.ld_inst  = 1'b1;
                o_next_state   = F1;
            end
            F1: begin
                o_ctl.sel_inc = 1'b1;
                o_ctl.ld_pc   = 1'b1;
                // A GOTO's first execute cycle is J0 itself; that is what gives
                // the 6/7/8-clock jump latencies instead of one more for EX0.
                o_next_state  = op_is(i_inst, GOTO_MASK, GOTO_MATCH) ? J0 : EX0;
            end
            EX0: begin
                o_next_state = w_done_state;
                if (i_inst == HALT_OPCODE) begin
                    o_next_state = HALT;
                end else if (op_is(i_inst, MOV_MASK, MOV_MATCH)) begin
                    o_sel = ONE << i_inst[2:0];
                    o_ld  = ONE << i_inst[5:3];
                end else if (op_is(i_inst, SETAB_MASK, SETAB_MATCH)) begin
                    o_ctl.imm_en = 1'b1;
                    o_imm_data   = {{3{i_inst[4]}}, i_inst[4:0]};
                    o_ld         = ONE << (i_inst[5] ? REG_B : REG_A);
                end else if (op_is(i_inst, ALU_MASK, ALU_MATCH)) begin
                    o_alu_fn = i_inst[2:0];
                    o_ld     = ONE << (i_inst[3] ? REG_D : REG_A);
                end else if (op_is(i_inst, LOAD_MASK, LOAD_MATCH)) begin
                    o_ctl.sel_m    = 1'b1;
                    o_ctl.mem_read = 1'b1;
                    o_ld           = ONE << i_inst[1:0];
                end else if (op_is(i_inst, STORE_MASK, STORE_MATCH)) begin
                    o_ctl.sel_m     = 1'b1;
                    o_ctl.mem_write = 1'b1;
                    o_sel           = ONE << i_inst[1:0];
                end else begin
                    o_illegal = 1'b1;
                end
            end
            J0: begin
                o_ctl.sel_pc   = 1'b1;
                o_ctl.ld_inc   = 1'b1;
                o_ctl.mem_read = 1'b1;
                o_ctl.ld_j1    = 1'b1;
                o_next_state   = J1;
            end
            J1: begin
                o_ctl.sel_inc = 1'b1;
                o_ctl.ld_pc   = 1'b1;
                o_next_state  = J2;
            end
            J2: begin
                o_ctl.sel_pc   = 1'b1;
                o_ctl.ld_inc   = 1'b1;
                o_ctl.mem_read = 1'b1;
                o_ctl.ld_j2    = 1'b1;
                o_next_state   = J3;
            end
            J3: begin
                o_ctl.sel_inc = 1'b1;
                o_ctl.ld_pc   = 1'b1;
                // Without a link, J3 is the state before J5 and decides the branch.
                if (w_link)       o_next_state = J4;
                else if (w_taken) o_next_state = J5;
                else              o_next_state = w_done_state;
            end
            J4: begin
                // PC already points past the target bytes: that is the return address.
                o_ctl.sel_inc = 1'b1;
                o_ctl.ld_xy   = 1'b1;
                o_next_state  = w_taken ? J5 : w_done_state;
            end
            J5: begin
                o_ctl.sel_j  = 1'b1;
                o_ctl.ld_pc  = 1'b1;
                o_next_state = w_done_state;
            end
            default: o_next_state = HALT;
        endcase
    end

endmodule

// File: rtl/instruction_sequencer.sv
// instruction_sequencer -- microsequencer for the relay-computer datapath.
// Holds only the state flop; every strobe is a Moore decode of state + inst.
//   clock, reset_n     : clock, asynchronous active-low reset (to HALT)
//   run                : leaving HALT / continuing after an instruction needs run=1
//   inst               : Inst register contents
//   flagZ/flagC/flagS  : condition flags for GOTO
//   ld, sel            : one-hot register-file load / bus-select strobes
//   ldJ1..ldXY         : program-control loads
//   selM..selINC       : address-bus source selects
//   aluFunctionCode    : ALU function
//   immEn, immData     : SETAB immediate onto the data bus
//   memRead, memWrite  : memory strobes
//   halted, illegal    : status
module instruction_sequencer
    import seq_pkg::*;
#(
    parameter int         NREGS       = NREGS_DEF,
    parameter logic [7:0] HALT_OPCODE = HALT_OPCODE_DEF
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             run,
    input  logic [7:0]       inst,
    input  logic             flagZ,
    input  logic             flagC,
    input  logic             flagS,
    output logic [NREGS-1:0] ld,
    output logic [NREGS-1:0] sel,
    output logic             ldJ1,
    output logic             ldJ2,
    output logic             ldInst,
    output logic             ldPC,
    output logic             ldINC,
    output logic             ldXY,
    output logic             selM,
    output logic             selXY,
    output logic             selJ,
    output logic             selPC,
    output logic             selINC,
    output logic [2:0]       aluFunctionCode,
    output logic             immEn,
    output logic [7:0]       immData,
    output logic             memRead,
    output logic             memWrite,
    output logic             halted,
    output logic             illegal
);

    state_t r_state;
    state_t w_next_state;
    ctl_t   w_ctl;

    // Reset forces HALT, whose decode is all-zero strobes, so the strobes
    // drop as soon as reset_n falls rather than at the next edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= HALT;
        else          r_state <= w_next_state;
    end

    seq_decode #(
        .NREGS       (NREGS),
        .HALT_OPCODE (HALT_OPCODE)
    ) u_decode (
        .i_state      (r_state),
        .i_inst       (inst),
        .i_run        (run),
        .i_flag_z     (flagZ),
        .i_flag_c     (flagC),
        .i_flag_s     (flagS),
        .o_next_state (w_next_state),
        .o_ld         (ld),
        .o_sel        (sel),
        .o_ctl        (w_ctl),
        .o_alu_fn     (aluFunctionCode),
        .o_imm_data   (immData),
        .o_halted     (halted),
        .o_illegal    (illegal)
    );

    assign ldJ1     = w_ctl.ld_j1;
    assign ldJ2     = w_ctl.ld_j2;
    assign ldInst   = w_ctl.ld_inst;
    assign ldPC     = w_ctl.ld_pc;
    assign ldINC    = w_ctl.ld_inc;
    assign ldXY     = w_ctl.ld_xy;
    assign selM     = w_ctl.sel_m;
    assign selXY    = w_ctl.sel_xy;
    assign selJ     = w_ctl.sel_j;
    assign selPC    = w_ctl.sel_pc;
    assign selINC   = w_ctl.sel_inc;
    assign immEn    = w_ctl.imm_en;
    assign memRead  = w_ctl.mem_read;
    assign memWrite = w_ctl.mem_write;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed bench for instruction_sequencer. An instruction-level model expands
// each opcode into its list of per-cycle output vectors; one compare process
// checks the DUT against that list on every falling edge, plus a few literal
// expectations attached to individual cycles.
module tb_instruction_sequencer;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       run;
    logic [7:0] inst;
    logic       flagZ, flagC, flagS;
    logic [7:0] ld, sel;
    logic       ldJ1, ldJ2, ldInst, ldPC, ldINC, ldXY;
    logic       selM, selXY, selJ, selPC, selINC;
    logic [2:0] aluFunctionCode;
    logic       immEn;
    logic [7:0] immData;
    logic       memRead, memWrite, halted, illegal;

    always #5 clock = ~clock;

    instruction_sequencer #(.NREGS(8), .HALT_OPCODE(8'hAE)) dut (
        .clock(clock), .reset_n(reset_n), .run(run), .inst(inst),
        .flagZ(flagZ), .flagC(flagC), .flagS(flagS),
        .ld(ld), .sel(sel),
        .ldJ1(ldJ1), .ldJ2(ldJ2), .ldInst(ldInst), .ldPC(ldPC), .ldINC(ldINC), .ldXY(ldXY),
        .selM(selM), .selXY(selXY), .selJ(selJ), .selPC(selPC), .selINC(selINC),
        .aluFunctionCode(aluFunctionCode), .immEn(immEn), .immData(immData),
        .memRead(memRead), .memWrite(memWrite), .halted(halted), .illegal(illegal)
    );

    typedef struct packed {
        logic [7:0] ld;
        logic [7:0] sel;
        logic ldJ1, ldJ2, ldInst, ldPC, ldINC, ldXY;
        logic selM, selXY, selJ, selPC, selINC;
        logic [2:0] alu;
        logic immEn;
        logic [7:0] immData;
        logic memRead, memWrite, halted, illegal;
    } obs_t;

    typedef struct {
        obs_t  exp;
        string tag;
        bit    has_lit;
        obs_t  lit;
        int    lit_len;
        int    mdl_len;
    } ent_t;

    obs_t dut_obs;
    assign dut_obs = {ld, sel, ldJ1, ldJ2, ldInst, ldPC, ldINC, ldXY,
                      selM, selXY, selJ, selPC, selINC, aluFunctionCode,
                      immEn, immData, memRead, memWrite, halted, illegal};

    ent_t exp_q[$];
    obs_t mseq[$];
    int   checks = 0;
    int   errors = 0;

    // ---------------- instruction-level model ----------------
    function automatic obs_t fetch_step(input bit is_j, input bit second);
        obs_t o = '0;
        o.selPC = 1'b1; o.ldINC = 1'b1; o.memRead = 1'b1;
        if (!is_j)       o.ldInst = 1'b1;
        else if (second) o.ldJ2 = 1'b1;
        else             o.ldJ1 = 1'b1;
        return o;
    endfunction

    function automatic obs_t advance_pc();
        obs_t o = '0;
        o.selINC = 1'b1; o.ldPC = 1'b1;
        return o;
    endfunction

    function automatic void model_instr(input logic [7:0] op, input logic z,
                                        input logic c, input logic s);
        obs_t x = '0;
        bit   taken;
        mseq.delete();
        mseq.push_back(fetch_step(1'b0, 1'b0));
        mseq.push_back(advance_pc());
        if (op[7:6] == 2'b11) begin
            taken = (op[3:0] == 4'd0) || (op[3] && s) || (op[2] && c) ||
                    (op[1] && z) || (op[0] && !z);
            mseq.push_back(fetch_step(1'b1, 1'b0));
            mseq.push_back(advance_pc());
            mseq.push_back(fetch_step(1'b1, 1'b1));
            mseq.push_back(advance_pc());
            if (op[5]) begin
                x = '0; x.selINC = 1'b1; x.ldXY = 1'b1;
                mseq.push_back(x);
            end
            if (taken) begin
                x = '0; x.selJ = 1'b1; x.ldPC = 1'b1;
                mseq.push_back(x);
            end
        end else begin
            if (op == 8'hAE) begin
                // parks the sequencer, no strobes
            end else if (op[7:6] == 2'b00) begin
                x.sel[op[2:0]] = 1'b1;
                x.ld[op[5:3]]  = 1'b1;
            end else if (op[7:6] == 2'b01) begin
                x.immEn   = 1'b1;
                x.immData = {{3{op[4]}}, op[4:0]};
                x.ld[op[5] ? 1 : 0] = 1'b1;
            end else if (op[7:4] == 4'b1000) begin
                x.alu = op[2:0];
                x.ld[op[3] ? 3 : 0] = 1'b1;
            end else if (op[7:2] == 6'b100100) begin
                x.selM = 1'b1; x.memRead = 1'b1;
                x.ld[op[1:0]] = 1'b1;
            end else if (op[7:2] == 6'b100110) begin
                x.selM = 1'b1; x.memWrite = 1'b1;
                x.sel[op[1:0]] = 1'b1;
            end else begin
                x.illegal = 1'b1;
            end
            mseq.push_back(x);
        end
    endfunction

    function automatic obs_t halt_obs();
        obs_t o = '0;
        o.halted = 1'b1;
        return o;
    endfunction

    function automatic void push(input obs_t e, input string tag, input bit has_lit,
                                 input obs_t lit, input int lit_len, input int mdl_len);
        ent_t t;
        t.exp = e; t.tag = tag; t.has_lit = has_lit; t.lit = lit;
        t.lit_len = lit_len; t.mdl_len = mdl_len;
        exp_q.push_back(t);
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clock) begin
        ent_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (dut_obs !== e.exp) begin
                errors++;
                $display("FAIL %s outputs got %h expected %h", e.tag, dut_obs, e.exp);
            end
            if (e.has_lit) begin
                checks++;
                if (dut_obs !== e.lit) begin
                    errors++;
                    $display("FAIL %s literal got %h expected %h", e.tag, dut_obs, e.lit);
                end
            end
            if (e.lit_len >= 0) begin
                checks++;
                if (e.mdl_len != e.lit_len) begin
                    errors++;
                    $display("FAIL %s latency got %0d expected %0d", e.tag, e.mdl_len, e.lit_len);
                end
            end
            checks++;
            if ($countones(dut_obs.ld) > 1 || $countones(dut_obs.sel) > 1) begin
                errors++;
                $display("FAIL %s onehot ld=%b sel=%b expected at most one bit each",
                         e.tag, dut_obs.ld, dut_obs.sel);
            end
        end
    end

    // ---------------- stimulus ----------------
    // Called just after the edge that entered F0. Flags f = {Z,C,S}; at cycle
    // chg the flags switch to f1 and run to run1. lit pins cycle lit_idx.
    task automatic do_instr(input string name, input logic [7:0] op,
                            input logic [2:0] f0, input logic [2:0] f1,
                            input logic run1, input int chg,
                            input int lit_idx, input obs_t lit, input int lit_len);
        int n;
        model_instr(op, f1[2], f1[1], f1[0]);
        n = mseq.size();
        inst = op;
        {flagZ, flagC, flagS} = f0;
        run = 1'b1;
        for (int i = 0; i < n; i++)
            push(mseq[i], $sformatf("%s c%0d", name, i), (i == lit_idx), lit,
                 (i == 0) ? lit_len : -1, n);
        for (int i = 0; i < n; i++) begin
            if (i == chg) begin
                {flagZ, flagC, flagS} = f1;
                run = run1;
            end
            @(posedge clock); #1;
        end
        $display("instr %-10s op=%h cycles=%0d", name, op, n);
    endtask

    task automatic do_halt(input int n, input logic run_lvl);
        obs_t none = '0;
        run = run_lvl;
        for (int i = 0; i < n; i++) begin
            push(halt_obs(), $sformatf("halt run=%0b c%0d", run_lvl, i), 1'b0, none, -1, 0);
            @(posedge clock); #1;
        end
        $display("halt run=%0b cycles=%0d", run_lvl, n);
    endtask

    initial begin
        obs_t L;
        obs_t none;
        none = '0;
        reset_n = 1'b0; run = 1'b1; inst = 8'h00;
        flagZ = 1'b0; flagC = 1'b0; flagS = 1'b0;

        // Reset held with run=1: stays HALT. Release mid-cycle, F0 follows.
        L = '0; L.halted = 1'b1;
        push(halt_obs(), "reset c0", 1'b1, L, -1, 0);
        push(halt_obs(), "reset c1", 1'b1, L, -1, 0);
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(posedge clock); #1;
        $display("reset released");

        L = '0; L.ld = 8'h01; L.sel = 8'h08;
        do_instr("MOV_A_D", 8'h03, 3'b000, 3'b000, 1'b1, 0, 2, L, 3);
        L = '0; L.selPC = 1'b1; L.ldINC = 1'b1; L.memRead = 1'b1; L.ldInst = 1'b1;
        do_instr("F0_pin", 8'h03, 3'b000, 3'b000, 1'b1, 0, 0, L, 3);
        L = '0; L.immEn = 1'b1; L.immData = 8'hFE; L.ld = 8'h01;
        do_instr("SETAB_A", 8'h5E, 3'b000, 3'b000, 1'b1, 0, 2, L, 3);
        L = '0; L.alu = 3'b101; L.ld = 8'h08;
        do_instr("ALU_D", 8'h8D, 3'b000, 3'b000, 1'b1, 0, 2, L, 3);
        do_instr("LOAD_C", 8'h92, 3'b000, 3'b000, 1'b1, 0, -1, none, 3);
        L = '0; L.selM = 1'b1; L.memWrite = 1'b1; L.sel = 8'h08;
        do_instr("STORE_D", 8'h9B, 3'b000, 3'b000, 1'b1, 0, 2, L, 3);
        do_instr("MOV_self", 8'h2D, 3'b000, 3'b000, 1'b1, 0, -1, none, 3);
        do_instr("SETAB_B", 8'h65, 3'b000, 3'b000, 1'b1, 0, -1, none, 3);

        L = '0; L.selINC = 1'b1; L.ldXY = 1'b1;
        do_instr("JL_Z_tk", 8'hE2, 3'b100, 3'b100, 1'b1, 0, 6, L, 8);
        do_instr("JL_Z_nt", 8'hE2, 3'b000, 3'b000, 1'b1, 0, -1, none, 7);
        L = '0; L.selJ = 1'b1; L.ldPC = 1'b1;
        do_instr("J_always", 8'hD0, 3'b000, 3'b000, 1'b1, 0, 6, L, 7);
        do_instr("J_C_nt", 8'hC4, 3'b101, 3'b101, 1'b1, 0, -1, none, 6);
        do_instr("JL_S_tk", 8'hE8, 3'b001, 3'b001, 1'b1, 0, -1, none, 8);
        do_instr("J_Z_late", 8'hC2, 3'b000, 3'b100, 1'b1, 4, -1, none, 7);
        do_instr("J_NZ_late", 8'hC1, 3'b000, 3'b100, 1'b1, 4, -1, none, 6);

        L = '0; L.illegal = 1'b1;
        do_instr("ILL_B1", 8'hB1, 3'b000, 3'b000, 1'b1, 0, 2, L, 3);
        do_instr("ILL_94", 8'h94, 3'b000, 3'b000, 1'b1, 0, -1, none, 3);

        // HALT opcode parks; run low keeps it parked; raising run resumes.
        do_instr("HALT_OP", 8'hAE, 3'b000, 3'b000, 1'b0, 1, 2, none, 3);
        do_halt(3, 1'b0);
        do_halt(1, 1'b1);

        // run dropped mid-instruction: the instruction completes, then HALT.
        do_instr("MOV_stop", 8'h08, 3'b000, 3'b000, 1'b0, 1, -1, none, 3);
        do_halt(2, 1'b0);
        do_halt(1, 1'b1);
        do_instr("JL_stop", 8'hE2, 3'b100, 3'b100, 1'b0, 3, -1, none, 8);
        do_halt(1, 1'b0);
        do_halt(1, 1'b1);

        // Reset during J2 of a GOTO: strobes clear before the next edge.
        model_instr(8'hE2, 1'b1, 1'b0, 1'b0);
        inst = 8'hE2; {flagZ, flagC, flagS} = 3'b100; run = 1'b1;
        for (int i = 0; i < 4; i++)
            push(mseq[i], $sformatf("JL_rst c%0d", i), 1'b0, none, -1, 0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clock); #1;
        end
        reset_n = 1'b0;
        L = '0; L.halted = 1'b1;
        push(halt_obs(), "rst_in_J2", 1'b1, L, -1, 0);
        @(posedge clock); #1;
        push(halt_obs(), "rst_held", 1'b0, none, -1, 0);
        reset_n = 1'b1;
        @(posedge clock); #1;
        $display("reset during J2 then released");
        do_instr("MOV_after", 8'h03, 3'b000, 3'b000, 1'b1, 0, -1, none, 3);

        @(posedge clock); #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
